// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM state codes, opcode/funct
// constants and the datapath mux/ALU select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    function automatic logic funct_supported(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational opcode/funct classifier; exactly one output is high for any input.
module instr_class
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       rtype,
    output logic       lw,
    output logic       sw,
    output logic       beq,
    output logic       addi,
    output logic       j,
    output logic       illegal
);

    always_comb begin
        // An R-type opcode with an unknown funct is classified illegal, not rtype.
        rtype   = (opcode == OP_RTYPE) && funct_supported(funct);
        lw      = (opcode == OP_LW);
        sw      = (opcode == OP_SW);
        beq     = (opcode == OP_BEQ);
        addi    = (opcode == OP_ADDI);
        j       = (opcode == OP_J);
        illegal = !(rtype || lw || sw || beq || addi || j);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for a multicycle MIPS-subset datapath. Outputs come
// from the state register; pc_en and the DECODE-cycle illegal pulse also see inputs.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        pc_write,
    output logic        branch,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic [3:0]  state,
    output logic        illegal
);

    state_t state_q, state_d;

    logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, is_illegal;
    logic ir_write_s, pc_write_s, branch_s, mem_write_s, reg_write_s, illegal_s;

    // Only opcode and funct are decoded here; the remaining fields feed the datapath.
    logic unused_instr;
    assign unused_instr = ^instr[25:6];

    instr_class u_class (
        .opcode  (instr[31:26]),
        .funct   (instr[5:0]),
        .rtype   (is_rtype),
        .lw      (is_lw),
        .sw      (is_sw),
        .beq     (is_beq),
        .addi    (is_addi),
        .j       (is_j),
        .illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        ir_write_s  = 1'b0;
        i_or_d      = 1'b0;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        pc_src      = PC_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_op      = ALU_ADD;
        mem_write_s = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                pc_write_s = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                illegal_s = is_illegal;
                if (is_lw || is_sw) state_d = S_MEMADR;
                else if (is_rtype)  state_d = S_EXEC;
                else if (is_beq)    state_d = S_BRANCH;
                else if (is_addi)   state_d = S_ADDIEX;
                else if (is_j)      state_d = S_JUMP;
                else                state_d = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                // If the IR no longer holds a load/store, abandon rather than guess.
                if (is_lw)      state_d = S_MEMRD;
                else if (is_sw) state_d = S_MEMWR;
                else            state_d = S_FETCH;
            end
            S_MEMRD: begin
                i_or_d  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                i_or_d      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                branch_s  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_s = 1'b1;
            end
            S_JUMP: begin
                pc_src     = PC_JUMP;
                pc_write_s = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // While reset is held the register sits in FETCH; mask its write strobes.
    assign ir_write  = ir_write_s  & rst_n;
    assign pc_write  = pc_write_s  & rst_n;
    assign branch    = branch_s    & rst_n;
    assign mem_write = mem_write_s & rst_n;
    assign reg_write = reg_write_s & rst_n;
    assign illegal   = illegal_s   & rst_n;
    assign pc_en     = rst_n & (pc_write_s | (branch_s & zero));
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected state/illegal per cycle is queued
// when an instruction is driven and compared each cycle against a reference table.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        ir_write, i_or_d, pc_write, branch, pc_en;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic        alu_src_a, mem_write, mem_to_reg, reg_dst, reg_write, illegal;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       ill;
    } exp_t;

    exp_t sb[$];

    multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .zero       (zero),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .pc_write   (pc_write),
        .branch     (branch),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [16:0] obs;
    assign obs = {ir_write, i_or_d, pc_write, branch, pc_en, pc_src, alu_src_a,
                  alu_src_b, alu_op, mem_write, mem_to_reg, reg_dst, reg_write, illegal};

    // Reference output table, one row per state.
    function automatic logic [16:0] ref_out(input logic [3:0] st, input logic ill, input logic z);
        logic irw, iod, pcw, br, pce, sa, mw, m2r, rd, rw, il;
        logic [1:0] ps, sb2, op;
        {irw, iod, pcw, br, pce, sa, mw, m2r, rd, rw, il} = '0;
        ps = 2'b00; sb2 = 2'b00; op = 2'b00;
        case (st)
            4'd0:  begin irw = 1; pcw = 1; pce = 1; sb2 = 2'b01; end
            4'd1:  begin sb2 = 2'b11; il = ill; end
            4'd2:  begin sa = 1; sb2 = 2'b10; end
            4'd3:  begin iod = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin iod = 1; mw = 1; end
            4'd6:  begin sa = 1; op = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; op = 2'b01; ps = 2'b01; br = 1; pce = z; end
            4'd9:  begin sa = 1; sb2 = 2'b10; end
            4'd10: begin rw = 1; end
            4'd11: begin ps = 2'b10; pcw = 1; pce = 1; end
            default: ;
        endcase
        return {irw, iod, pcw, br, pce, ps, sa, sb2, op, mw, m2r, rd, rw, il};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic ill);
        sb.push_back('{st: st, ill: ill});
    endtask

    // Called at a falling edge: compare one queued cycle, then move to the next falling edge.
    task automatic step(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            #1;
            check({tag, "_state"}, {28'd0, state}, {28'd0, e.st});
            check({tag, "_outs"}, {15'd0, obs}, {15'd0, ref_out(e.st, e.ill, zero)});
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (sb.size() > 0 && guard < 64) begin
            step(tag);
            guard++;
        end
        check({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        instr = 32'h012A4020;
        zero  = 1'b1;

        // Reset: FETCH code with every write strobe masked, even across a clock edge.
        #2;
        check("rst_state", {28'd0, state}, 32'd0);
        check("rst_strobes", {26'd0, ir_write, pc_write, branch, pc_en, mem_write, reg_write},
              32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk); #1;
        check("rst_hold_state", {28'd0, state}, 32'd0);
        check("rst_hold_irw", {31'd0, ir_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        zero  = 1'b0;

        // add
        push(0, 0); push(1, 0); push(6, 0); push(7, 0);
        drain("add");

        // lw
        instr = 32'h8D090004;
        push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(4, 0);
        drain("lw");

        // sw
        instr = 32'hAD090004;
        push(0, 0); push(1, 0); push(2, 0); push(5, 0);
        drain("sw");

        // beq taken then not taken
        instr = 32'h11090002;
        zero  = 1'b1;
        push(0, 0); push(1, 0); push(8, 0);
        drain("beq_z1");
        zero  = 1'b0;
        push(0, 0); push(1, 0); push(8, 0);
        drain("beq_z0");

        // addi
        instr = 32'h21090005;
        push(0, 0); push(1, 0); push(9, 0); push(10, 0);
        drain("addi");

        // j
        instr = 32'h08000010;
        push(0, 0); push(1, 0); push(11, 0);
        drain("j");

        // Unsupported opcode, then R-type with an unsupported funct
        instr = 32'hFC000000;
        push(0, 0); push(1, 1);
        drain("ill_op");
        instr = 32'h012A4000;
        push(0, 0); push(1, 1);
        drain("ill_funct");

        // IR overwritten in EXEC must not disturb the R-type sequence
        instr = 32'h012A4022;
        push(0, 0); push(1, 0); push(6, 0); push(7, 0);
        step("irchg"); step("irchg");
        instr = 32'hFC000000;
        step("irchg"); step("irchg");
        check("irchg_drained", sb.size(), 0);

        // Reset pulse during MEMRD of a lw
        instr = 32'h8D090004;
        push(0, 0); push(1, 0); push(2, 0);
        drain("lw_abort");
        #1;
        check("abort_in_memrd", {28'd0, state}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_async_state", {28'd0, state}, 32'd0);
        check("abort_strobes", {29'd0, reg_write, mem_write, ir_write}, 32'd0);
        @(posedge clk); #1;
        check("abort_no_memwb", {28'd0, state}, 32'd0);
        check("abort_no_regwr", {31'd0, reg_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(4, 0); push(0, 0);
        drain("lw_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 instr  input  32  current instruction register contents; opcode is [31:26], funct is [5:0].
REQ-005 zero  input  1  ALU zero flag from the current cycle.
REQ-006 ir_write  output  1  load the instruction register from memory data.
REQ-007 i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 pc_write  output  1  unconditional PC update.
REQ-009 branch  output  1  conditional PC update, qualified by zero.
REQ-010 pc_en  output  1  combinational PC enable, equal to pc_write OR (branch AND zero).
REQ-011 pc_src  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], instr[25:0], 2'b00}.
REQ-012 alu_src_a  output  1  ALU A operand: 0 = PC, 1 = register A.
REQ-013 alu_src_b  output  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-014 alu_op  output  2  ALU operation: 00 = add, 01 = subtract, 10 = decode from funct.
REQ-015 mem_write, mem_to_reg, reg_dst, reg_write  output  1 each  same meaning as the single-cycle decoder signals of the same names.
REQ-016 state  output  4  current FSM state code, for debug.
REQ-017 illegal  output  1  one-cycle pulse when an unsupported instruction is decoded.

Function
REQ-018 The block SHALL be a Moore FSM; all outputs except pc_en SHALL be decoded from the state register only.
REQ-019 States and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-020 Codes 12 to 15 are unreachable and SHALL transition to FETCH with all enables low.
REQ-021 Supported instructions: R-type add/sub/and/or/slt (opcode 0x00, funct 0x20/0x22/0x24/0x25/0x2A), lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
REQ-022 FETCH: i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_write=1; next state DECODE.
REQ-023 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
REQ-024 DECODE next state: lw/sw to MEMADR, R-type to EXEC, beq to BRANCH, addi to ADDIEX, j to JUMP, anything else to FETCH with illegal=1.
REQ-025 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEMRD for lw, MEMWR for sw.
REQ-026 MEMRD: i_or_d=1; next state MEMWB.
REQ-027 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next state FETCH.
REQ-028 MEMWR: i_or_d=1, mem_write=1; next state FETCH.
REQ-029 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state ALUWB.
REQ-030 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-031 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1; next state FETCH.
REQ-032 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDIWB.
REQ-033 ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; next state FETCH.
REQ-034 JUMP: pc_src=10, pc_write=1; next state FETCH.
REQ-035 Any output not listed for a state SHALL be 0.
REQ-036 Latency in cycles, FETCH inclusive: lw 5; R-type, sw and addi 4; beq and j 3.
REQ-037 instr SHALL be used only in DECODE and MEMADR, so a mid-instruction IR change outside those states has no effect.

Reset
REQ-038 While rst_n is low, state SHALL be FETCH and ir_write, pc_write, branch, pc_en, mem_write, reg_write and illegal SHALL be forced to 0.
REQ-039 The first FETCH actions SHALL occur on the first rising edge of clk after rst_n deasserts.
REQ-040 Reset asserted mid-instruction SHALL abort that instruction immediately, with no completing writes.

Structure
REQ-041 A shared package ctrl_pkg SHALL hold the state enum, opcode/funct constants, and alu_op, pc_src and alu_src_b encodings.
REQ-042 Opcode/funct classification SHALL be one combinational sub-module, instr_class, producing one-hot rtype/lw/sw/beq/addi/j/illegal outputs.

Verification
REQ-043 instr=0x012A4020 (add) -> states 0,1,6,7,0; in ALUWB reg_write=1 and reg_dst=1; illegal stays 0.
REQ-044 instr=0x8D090004 (lw) -> states 0,1,2,3,4,0; i_or_d=1 in MEMRD; mem_to_reg=1 and reg_write=1 in MEMWB.
REQ-045 instr=0x11090002 (beq) -> with zero=1 in BRANCH, pc_en=1 and pc_src=01; repeat with zero=0 -> pc_en=0.
REQ-046 instr=0x08000010 (j) -> states 0,1,11,0; pc_en=1 and pc_src=10 in JUMP.
REQ-047 instr=0xFC000000 -> illegal=1 for exactly the DECODE cycle; next state FETCH; reg_write and mem_write never asserted.
REQ-048 rst_n pulsed low during MEMRD of a lw -> state reads 0 asynchronously, no MEMWB occurs, and a normal FETCH follows release.
